// File: rtl/yuv422_to_gray.sv
`default_nettype none
// ============================================================================
// Module      : yuv422_to_gray
// Description : Keeps the luma lanes of a packed YUV422 AXI-Stream and
//               discards the chroma. Output register plus one-entry skid
//               buffer; also flags line/frame framing errors.
// Revision    : 1.0 - initial release
// ============================================================================
module yuv422_to_gray #(
    parameter int DATA_WIDTH  = 8,
    parameter int PPC         = 4,
    parameter int LINE_BEATS  = 320,
    parameter int FRAME_LINES = 720
) (
    input  logic                         aclk,
    input  logic                         reset,
    input  logic                         s_axis_yuv_tvalid,
    input  logic [DATA_WIDTH*PPC*3-1:0]  s_axis_yuv_tdata,
    input  logic                         s_axis_yuv_tuser,
    input  logic                         s_axis_yuv_tlast,
    output logic                         s_axis_yuv_tready,
    output logic [DATA_WIDTH*PPC-1:0]    m_axis_gray_tdata,
    output logic                         m_axis_gray_tvalid,
    output logic                         m_axis_gray_tuser,
    output logic                         m_axis_gray_tlast,
    input  logic                         m_axis_gray_tready,
    output logic                         err_sof,
    output logic                         err_eol_early,
    output logic                         err_eol_late
);

    localparam int c_OUT_W  = DATA_WIDTH * PPC;
    localparam int c_BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam int c_LINE_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(LINE_BEATS - 1);
    localparam logic [c_LINE_W-1:0] c_LAST_LINE = c_LINE_W'(FRAME_LINES - 1);

    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_FULL  = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic                r_tready;
    logic                w_in_acc;
    logic                w_out_xfer;
    logic                w_load_out_in;
    logic                w_load_out_skid;
    logic                w_load_skid;
    logic [c_OUT_W-1:0]  w_gray;
    logic [c_OUT_W-1:0]  r_out_data;
    logic                r_out_user;
    logic                r_out_last;
    logic [c_OUT_W-1:0]  r_skid_data;
    logic                r_skid_user;
    logic                r_skid_last;

    logic [c_BEAT_W-1:0] r_beat;
    logic [c_LINE_W-1:0] r_line;
    logic [c_BEAT_W-1:0] w_beat_eff;
    logic [c_LINE_W-1:0] w_line_eff;
    logic [c_LINE_W-1:0] w_line_nxt;
    logic                w_at_last;
    logic                w_line_end;
    logic                r_err_sof;
    logic                r_err_early;
    logic                r_err_late;

    // Chroma and spare lanes are intentionally dropped.
    logic w_unused_tdata;
    assign w_unused_tdata = ^s_axis_yuv_tdata;

    for (genvar k = 0; k < PPC; k++) begin : g_lane
        assign w_gray[k*DATA_WIDTH +: DATA_WIDTH] =
            s_axis_yuv_tdata[2*k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_in_acc   = s_axis_yuv_tvalid && r_tready;
    assign w_out_xfer = m_axis_gray_tvalid && m_axis_gray_tready;

    // Ready is the registered "not FULL" so downstream ready never reaches it combinationally.
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state  <= c_EMPTY;
            r_tready <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_tready <= (w_next_state != c_FULL);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_EMPTY: if (w_in_acc) w_next_state = c_ONE;
            c_ONE: begin
                if (w_in_acc && !w_out_xfer)      w_next_state = c_FULL;
                else if (!w_in_acc && w_out_xfer) w_next_state = c_EMPTY;
            end
            c_FULL:  if (w_out_xfer) w_next_state = c_ONE;
            default: w_next_state = c_EMPTY;
        endcase
    end

    always_comb begin
        w_load_out_in      = 1'b0;
        w_load_out_skid    = 1'b0;
        w_load_skid        = 1'b0;
        m_axis_gray_tvalid = (r_state != c_EMPTY);
        case (r_state)
            c_EMPTY: w_load_out_in = w_in_acc;
            c_ONE: begin
                w_load_out_in = w_in_acc && w_out_xfer;
                w_load_skid   = w_in_acc && !w_out_xfer;
            end
            c_FULL:  w_load_out_skid = w_out_xfer;
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_user  <= 1'b0;
            r_out_last  <= 1'b0;
            r_skid_data <= '0;
            r_skid_user <= 1'b0;
            r_skid_last <= 1'b0;
        end else begin
            if (w_load_out_in) begin
                r_out_data <= w_gray;
                r_out_user <= s_axis_yuv_tuser;
                r_out_last <= s_axis_yuv_tlast;
            end else if (w_load_out_skid) begin
                r_out_data <= r_skid_data;
                r_out_user <= r_skid_user;
                r_out_last <= r_skid_last;
            end
            if (w_load_skid) begin
                r_skid_data <= w_gray;
                r_skid_user <= s_axis_yuv_tuser;
                r_skid_last <= s_axis_yuv_tlast;
            end
        end
    end

    assign s_axis_yuv_tready = r_tready;
    assign m_axis_gray_tdata = r_out_data;
    assign m_axis_gray_tuser = r_out_user;
    assign m_axis_gray_tlast = r_out_last;

    // Start-of-frame restarts the position before the beat itself is counted.
    always_comb begin
        w_beat_eff = s_axis_yuv_tuser ? '0 : r_beat;
        w_line_eff = s_axis_yuv_tuser ? '0 : r_line;
        w_at_last  = (w_beat_eff == c_LAST_BEAT);
        w_line_end = s_axis_yuv_tlast || w_at_last;
        w_line_nxt = (w_line_eff == c_LAST_LINE) ? '0 : w_line_eff + c_LINE_W'(1);
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_beat      <= '0;
            r_line      <= '0;
            r_err_sof   <= 1'b0;
            r_err_early <= 1'b0;
            r_err_late  <= 1'b0;
        end else if (w_in_acc) begin
            if (s_axis_yuv_tuser && ((r_beat != '0) || (r_line != '0)))
                r_err_sof <= 1'b1;
            if (s_axis_yuv_tlast && !w_at_last)
                r_err_early <= 1'b1;
            if (!s_axis_yuv_tlast && w_at_last)
                r_err_late <= 1'b1;
            if (w_line_end) begin
                r_beat <= '0;
                r_line <= w_line_nxt;
            end else begin
                r_beat <= w_beat_eff + c_BEAT_W'(1);
                r_line <= w_line_eff;
            end
        end
    end

    assign err_sof       = r_err_sof;
    assign err_eol_early = r_err_early;
    assign err_eol_late  = r_err_late;

endmodule
`default_nettype wire

// File: tb/tb_yuv422_to_gray.sv
`default_nettype none
// ============================================================================
// Module      : tb_yuv422_to_gray
// Description : Scoreboard bench; instance 0 uses full-size line/frame,
//               instance 1 a 4x3 frame for the randomised stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_yuv422_to_gray;

    typedef struct packed {
        logic [31:0] d;
        logic        u;
        logic        l;
    } beat_t;

    logic        aclk  = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid [2];
    logic [95:0] s_data  [2];
    logic        s_user  [2];
    logic        s_last  [2];
    logic        s_ready [2];
    logic [31:0] m_data  [2];
    logic        m_valid [2];
    logic        m_user  [2];
    logic        m_last  [2];
    logic        m_ready [2];
    logic        e_sof   [2];
    logic        e_early [2];
    logic        e_late  [2];

    beat_t q0[$];
    beat_t q1[$];
    int    n_tests   = 0;
    int    n_fail    = 0;
    int    rmode [2] = '{0, 0};
    int    cyc       = 0;
    int    first_out = 0;
    int    last_out  = 0;
    int    out_cnt0  = 0;

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    yuv422_to_gray #(.DATA_WIDTH(8), .PPC(4), .LINE_BEATS(320), .FRAME_LINES(720)) u_dut (
        .aclk(aclk), .reset(reset),
        .s_axis_yuv_tvalid(s_valid[0]), .s_axis_yuv_tdata(s_data[0]),
        .s_axis_yuv_tuser(s_user[0]), .s_axis_yuv_tlast(s_last[0]),
        .s_axis_yuv_tready(s_ready[0]),
        .m_axis_gray_tdata(m_data[0]), .m_axis_gray_tvalid(m_valid[0]),
        .m_axis_gray_tuser(m_user[0]), .m_axis_gray_tlast(m_last[0]),
        .m_axis_gray_tready(m_ready[0]),
        .err_sof(e_sof[0]), .err_eol_early(e_early[0]), .err_eol_late(e_late[0]));

    yuv422_to_gray #(.DATA_WIDTH(8), .PPC(4), .LINE_BEATS(4), .FRAME_LINES(3)) u_dut_small (
        .aclk(aclk), .reset(reset),
        .s_axis_yuv_tvalid(s_valid[1]), .s_axis_yuv_tdata(s_data[1]),
        .s_axis_yuv_tuser(s_user[1]), .s_axis_yuv_tlast(s_last[1]),
        .s_axis_yuv_tready(s_ready[1]),
        .m_axis_gray_tdata(m_data[1]), .m_axis_gray_tvalid(m_valid[1]),
        .m_axis_gray_tuser(m_user[1]), .m_axis_gray_tlast(m_last[1]),
        .m_axis_gray_tready(m_ready[1]),
        .err_sof(e_sof[1]), .err_eol_early(e_early[1]), .err_eol_late(e_late[1]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int qsize(input int idx);
        return (idx == 0) ? q0.size() : q1.size();
    endfunction

    // Lanes 8..11 carry junk that must never reach the output.
    function automatic logic [95:0] mk(input logic [7:0] y0, y1, y2, y3);
        return {8'hAA, 8'h55, 8'hCC, 8'h33, 8'h80, y3, 8'h80, y2, 8'h80, y1, 8'h80, y0};
    endfunction

    task automatic sync();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input int idx, input logic [7:0] y0, y1, y2, y3,
                        input logic u, input logic l);
        bit    acc;
        int    guard;
        beat_t e;
        acc   = 1'b0;
        guard = 0;
        s_data[idx]  = mk(y0, y1, y2, y3);
        s_user[idx]  = u;
        s_last[idx]  = l;
        s_valid[idx] = 1'b1;
        while (!acc) begin
            @(negedge aclk);
            acc = s_ready[idx];
            @(posedge aclk);
            guard++;
            if (!acc && guard > 2000) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: dut %0d got ready=0 expected ready=1", idx);
                #1;
                return;
            end
        end
        e = '{d: {y3, y2, y1, y0}, u: u, l: l};
        if (idx == 0) q0.push_back(e);
        else          q1.push_back(e);
        #1;
    endtask

    task automatic drain(input int idx);
        int g;
        g = 0;
        s_valid[idx] = 1'b0;
        while (qsize(idx) != 0 && g < 2000) begin
            @(posedge aclk);
            g++;
        end
        chk("drain_empty", 64'(qsize(idx)), 64'd0);
        sync();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        s_valid[0] = 1'b0;
        s_valid[1] = 1'b0;
        q0.delete();
        q1.delete();
        repeat (2) sync();
        reset = 1'b0;
        sync();
    endtask

    task automatic chk_err(input int idx, input string tag,
                           input logic sof, input logic early, input logic late);
        chk({tag, "_err_sof"},   64'(e_sof[idx]),   64'(sof));
        chk({tag, "_err_early"}, 64'(e_early[idx]), 64'(early));
        chk({tag, "_err_late"},  64'(e_late[idx]),  64'(late));
    endtask

    // Sink-ready patterns: 0 always, 1 the 1,0,0,1 cycle, 2 random, 3 never.
    initial begin
        int ph;
        ph = 0;
        m_ready[0] = 1'b1;
        m_ready[1] = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            for (int i = 0; i < 2; i++) begin
                case (rmode[i])
                    0:       m_ready[i] = 1'b1;
                    1:       m_ready[i] = ((ph % 4) == 0) || ((ph % 4) == 3);
                    2:       m_ready[i] = 1'($urandom_range(0, 1));
                    default: m_ready[i] = 1'b0;
                endcase
            end
            ph++;
        end
    end

    // Monitor: the queue depth equals the DUT occupancy at each falling edge.
    initial begin
        logic [33:0] hold_v [2];
        bit          held   [2];
        int          since  [2];
        beat_t       e;
        held  = '{0, 0};
        since = '{0, 0};
        forever begin
            @(negedge aclk);
            for (int i = 0; i < 2; i++) begin
                if (reset) begin
                    since[i] = 0;
                    held[i]  = 0;
                end else begin
                    since[i]++;
                end
                if (since[i] >= 2) begin
                    chk("s_tready_vs_occupancy", 64'(s_ready[i]), 64'(qsize(i) != 2));
                    if (held[i]) begin
                        chk("stall_hold_valid", 64'(m_valid[i]), 64'd1);
                        chk("stall_hold_beat", 64'({m_data[i], m_user[i], m_last[i]}),
                            64'(hold_v[i]));
                    end
                    if (m_valid[i] && m_ready[i]) begin
                        if (qsize(i) == 0) begin
                            chk("unexpected_output", 64'(m_data[i]), 64'hDEAD_BEEF_0000_0000);
                        end else begin
                            e = (i == 0) ? q0.pop_front() : q1.pop_front();
                            chk("out_beat", 64'({m_data[i], m_user[i], m_last[i]}), 64'(e));
                        end
                        if (i == 0) begin
                            if (out_cnt0 == 0) first_out = cyc;
                            last_out = cyc;
                            out_cnt0++;
                        end
                    end
                    held[i]   = m_valid[i] && !m_ready[i];
                    hold_v[i] = {m_data[i], m_user[i], m_last[i]};
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            s_valid[i] = 1'b0;
            s_data[i]  = '0;
            s_user[i]  = 1'b0;
            s_last[i]  = 1'b0;
        end
        reset = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_tvalid", 64'(m_valid[i]), 64'd0);
            chk("rst_tdata",  64'(m_data[i]),  64'd0);
            chk("rst_tuser",  64'(m_user[i]),  64'd0);
            chk("rst_tlast",  64'(m_last[i]),  64'd0);
            chk("rst_tready", 64'(s_ready[i]), 64'd0);
            chk_err(i, "rst", 1'b0, 1'b0, 1'b0);
        end
        sync();
        reset = 1'b0;
        @(negedge aclk);
        chk("tready_before_first_edge", 64'(s_ready[0]), 64'd0);
        @(posedge aclk);
        @(negedge aclk);
        chk("tready_after_reset", 64'(s_ready[0]), 64'd1);
        sync();

        // Lane extraction, one-cycle latency
        rmode[0] = 0;
        send(0, 8'h10, 8'h20, 8'h30, 8'hF0, 1'b1, 1'b0);
        s_valid[0] = 1'b0;
        @(negedge aclk);
        chk("lane_tvalid", 64'(m_valid[0]), 64'd1);
        chk("lane_tdata",  64'(m_data[0]),  64'hF030_2010);
        chk("lane_tuser",  64'(m_user[0]),  64'd1);
        sync();
        drain(0);

        // Backpressure with the 1,0,0,1 sink pattern
        do_reset();
        rmode[0] = 1;
        for (int b = 0; b < 8; b++)
            send(0, 8'(4*b), 8'(4*b+1), 8'(4*b+2), 8'(4*b+3), b == 0, 1'b0);
        drain(0);
        rmode[0] = 0;

        // Full-rate line
        do_reset();
        out_cnt0 = 0;
        for (int b = 0; b < 320; b++)
            send(0, 8'(b), 8'(b + 1), 8'(b + 2), 8'(b >> 1), b == 0, b == 319);
        drain(0);
        chk("thru_count", 64'(out_cnt0), 64'd320);
        chk("thru_span",  64'(last_out - first_out), 64'd319);
        chk_err(0, "thru", 1'b0, 1'b0, 1'b0);

        // Early end of line at beat 100
        do_reset();
        for (int b = 0; b <= 100; b++)
            send(0, 8'(b), 8'h01, 8'h02, 8'h03, b == 0, b == 100);
        s_valid[0] = 1'b0;
        @(negedge aclk);
        chk_err(0, "early", 1'b0, 1'b1, 1'b0);
        drain(0);
        do_reset();
        chk_err(0, "early_clr", 1'b0, 1'b0, 1'b0);

        // Missing tlast on beat 319
        for (int b = 0; b < 320; b++)
            send(0, 8'(b), 8'h11, 8'h12, 8'h13, b == 0, 1'b0);
        s_valid[0] = 1'b0;
        @(negedge aclk);
        chk_err(0, "late", 1'b0, 1'b0, 1'b1);
        drain(0);
        do_reset();
        chk_err(0, "late_clr", 1'b0, 1'b0, 1'b0);

        // Start of frame on line 5
        for (int ln = 0; ln < 5; ln++)
            for (int b = 0; b < 320; b++)
                send(0, 8'(b), 8'(ln), 8'h22, 8'h23, (ln == 0) && (b == 0), b == 319);
        s_valid[0] = 1'b0;
        @(negedge aclk);
        chk_err(0, "sof_pre", 1'b0, 1'b0, 1'b0);
        sync();
        send(0, 8'h5A, 8'h5B, 8'h5C, 8'h5D, 1'b1, 1'b0);
        s_valid[0] = 1'b0;
        @(negedge aclk);
        chk_err(0, "sof", 1'b1, 1'b0, 1'b0);
        drain(0);
        do_reset();
        chk_err(0, "sof_clr", 1'b0, 1'b0, 1'b0);

        // Reset while FULL
        rmode[0] = 3;
        sync();
        send(0, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1'b1, 1'b0);
        send(0, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 1'b0, 1'b0);
        s_valid[0] = 1'b0;
        @(negedge aclk);
        chk("full_tready", 64'(s_ready[0]), 64'd0);
        chk("full_tvalid", 64'(m_valid[0]), 64'd1);
        reset = 1'b1;
        q0.delete();
        @(posedge aclk);
        @(negedge aclk);
        chk("midrst_tvalid", 64'(m_valid[0]), 64'd0);
        sync();
        reset    = 1'b0;
        rmode[0] = 0;
        sync();
        send(0, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 1'b1, 1'b0);
        s_valid[0] = 1'b0;
        @(negedge aclk);
        chk_err(0, "midrst", 1'b0, 1'b0, 1'b0);
        drain(0);

        // Ten small frames, random valid and ready
        do_reset();
        rmode[1] = 2;
        for (int f = 0; f < 10; f++)
            for (int ln = 0; ln < 3; ln++)
                for (int b = 0; b < 4; b++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        s_valid[1] = 1'b0;
                        sync();
                    end
                    send(1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                         (ln == 0) && (b == 0), b == 3);
                end
        drain(1);
        chk_err(1, "rand", 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/yuv422_to_gray.md
YUV422_TO_GRAY -- requirements
Module: yuv422_to_gray

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 8, bits per sample; PPC, 4, pixels per beat; LINE_BEATS, 320, beats per line (1280 px / PPC); FRAME_LINES, 720, lines per frame.
REQ-002 aclk  in  1  single clock; every flop SHALL be clocked on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 s_axis_yuv_tvalid  in  1  input beat valid.
REQ-005 s_axis_yuv_tdata  in  DATA_WIDTH*PPC*3  packed YUV422 input; pixel k (0..PPC-1) SHALL carry Y in lane 2k and chroma in lane 2k+1; lanes 2*PPC and above SHALL be ignored.
REQ-006 s_axis_yuv_tuser  in  1  start of frame, asserted on the first beat of a frame.
REQ-007 s_axis_yuv_tlast  in  1  end of line.
REQ-008 s_axis_yuv_tready  out  1  input ready; driven directly by a flop.
REQ-009 m_axis_gray_tdata  out  DATA_WIDTH*PPC  Y of pixel k in lane k.
REQ-010 m_axis_gray_tvalid / tuser / tlast  out  1 each  output beat qualifiers.
REQ-011 m_axis_gray_tready  in  1  downstream ready.
REQ-012 err_sof  out  1  sticky: tuser seen at a position other than line 0, beat 0.
REQ-013 err_eol_early  out  1  sticky: tlast seen before beat LINE_BEATS-1.
REQ-014 err_eol_late  out  1  sticky: tlast missing at beat LINE_BEATS-1.

Function
REQ-015 A beat SHALL transfer on any edge where tvalid and tready are both high, on either port.
REQ-016 Extraction: out lane k SHALL be in lane 2k; chroma SHALL be discarded; no arithmetic SHALL be applied.
REQ-017 Datapath SHALL be a registered output stage plus a one-entry skid buffer; latency input-accept to m_axis_gray_tvalid SHALL be exactly 1 cycle when the skid is empty.
REQ-018 tuser and tlast SHALL travel with their beat through both the output stage and the skid.
REQ-019 s_axis_yuv_tready SHALL be high when the skid is empty and low when it is full; there SHALL be no combinational path from m_axis_gray_tready to s_axis_yuv_tready.
REQ-020 Storage states SHALL be EMPTY, ONE (output register valid), and FULL (output and skid valid).
REQ-021 EMPTY->ONE on accept; ONE->EMPTY on output transfer without accept; ONE->FULL on accept while output is stalled; FULL->ONE on output transfer, with the skid moving into the output register in the same cycle.
REQ-022 In ONE, a simultaneous accept and output transfer SHALL load the new beat into the output register and remain in ONE, giving full throughput.
REQ-023 Beat order SHALL be preserved; no beat SHALL be dropped or duplicated under any tready pattern.
REQ-024 While m_axis_gray_tvalid is high and m_axis_gray_tready is low, m_axis outputs SHALL hold stable.
REQ-025 Checker: beat counter (0..LINE_BEATS-1) and line counter (0..FRAME_LINES-1) SHALL advance only on accepted input beats.
REQ-026 On an accepted beat with tlast, or at beat LINE_BEATS-1, the beat counter SHALL clear and the line counter SHALL increment, wrapping FRAME_LINES-1 to 0.
REQ-027 An accepted tuser SHALL force both counters to beat 0, line 0 before the beat is counted; err_sof SHALL set if the counters were not already at 0/0.
REQ-028 tlast at beat < LINE_BEATS-1 SHALL set err_eol_early; beat LINE_BEATS-1 without tlast SHALL set err_eol_late; both SHALL resynchronise the counters per REQ-026.
REQ-029 Error flags SHALL never alter data, qualifiers or handshake, and SHALL clear only on reset.

Reset
REQ-030 While reset is high, the state SHALL be EMPTY, m_axis_gray_tvalid/tuser/tlast = 0, m_axis_gray_tdata = 0, s_axis_yuv_tready = 0, counters = 0 and error flags = 0.
REQ-031 s_axis_yuv_tready SHALL go to 1 on the first edge after reset deasserts.
REQ-032 Reset mid-frame SHALL discard buffered beats; the next accepted beat SHALL be treated as line 0, beat 0.

Verification
REQ-033 Lanes: input pixel0 Y=0x10 C=0x80, pixel1 Y=0x20, pixel2 Y=0x30, pixel3 Y=0xF0, tuser=1, sink always ready -> next cycle tdata=0xF0302010, tuser=1, tvalid=1.
REQ-034 Backpressure: stream 8 beats with incrementing Y while m_axis_gray_tready toggles 1,0,0,1 -> all 8 beats out in order, s_axis_yuv_tready low only in FULL, output stable across stalls.
REQ-035 Throughput: continuous valid/ready for LINE_BEATS beats with tlast on the final beat -> one output beat per cycle after the first, tlast on output beat 320, no error flag set.
REQ-036 Protocol errors: tlast at beat 100 -> err_eol_early=1; no tlast at beat 319 -> err_eol_late=1; tuser on line 5 -> err_sof=1; all flags clear after reset.
REQ-037 Reset mid-stream: assert reset while in FULL -> tvalid=0 the next cycle; after release, a tuser beat produces no err_sof.
REQ-038 Random: 10 frames with random valid/ready (50%) at LINE_BEATS=4, FRAME_LINES=3 -> scoreboard matches, all errors stay 0.
